ddr_cmd_arbiter: RTL and testbench

//  Shares the DDR command translator between NUM_REQ requesters (e.g. ifmap loader, weight loader, ofmap writer).

---
 rtl/ddr_arb_pkg.sv | 23 ++
 rtl/ddr_cmd_arbiter_rr.sv | 31 +++
 rtl/ddr_cmd_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_ddr_cmd_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR command arbiter.
package ddr_arb_pkg;

  localparam int unsigned LEN_W       = 32;
  localparam int unsigned MAX_CMD_LEN = 65535;
  localparam int unsigned NUM_CH      = 2;

  // Requester direction bit; the value doubles as the channel index.
  localparam logic DIR_WR = 1'b1;
  localparam logic DIR_RD = 1'b0;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_ISSUE = 2'd1,
    CH_WAIT  = 2'd2
  } ch_state_e;

  // A command length the translator can execute: 1..MAX_CMD_LEN beats.
  function automatic logic len_ok(input logic [LEN_W-1:0] len);
    return (len != '0) && (len <= LEN_W'(MAX_CMD_LEN));
  endfunction

endpackage

// File: rtl/ddr_cmd_arbiter_rr.sv
// Combinational round-robin pick: first eligible requester at or after ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner_oh_c,
  output logic [PTR_W-1:0]   winner_idx_c,
  output logic               valid_c
);

  logic [PTR_W-1:0] idx;

  // Scan NUM_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    winner_oh_c  = '0;
    winner_idx_c = '0;
    valid_c      = 1'b0;
    idx          = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((32'(ptr) + 32'(k)) % NUM_REQ);
      if (!valid_c && eligible[idx]) begin
        valid_c          = 1'b1;
        winner_oh_c[idx] = 1'b1;
        winner_idx_c     = idx;
      end
    end
  end

endmodule

// File: rtl/ddr_cmd_arbiter.sv
// Round-robin arbiter sharing one write and one read DDR command channel among NUM_REQ clients.
module ddr_cmd_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned CTRL_ADDR_WIDTH = 28,
  parameter int unsigned TIMEOUT_CYC     = 1048576
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ-1:0]                 req_dir,
  input  logic [NUM_REQ*CTRL_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]              req_len,
  output logic [NUM_REQ-1:0]                 grant,
  output logic [NUM_REQ-1:0]                 done,
  output logic [NUM_REQ-1:0]                 err,
  output logic                               wr_cmd_en,
  output logic [CTRL_ADDR_WIDTH-1:0]         wr_cmd_addr,
  output logic [31:0]                        wr_cmd_len,
  input  logic                               wr_cmd_ready,
  input  logic                               wr_cmd_done,
  output logic                               rd_cmd_en,
  output logic [CTRL_ADDR_WIDTH-1:0]         rd_cmd_addr,
  output logic [31:0]                        rd_cmd_len,
  input  logic                               rd_cmd_ready,
  input  logic                               rd_cmd_done,
  output logic                               busy
);

  localparam int unsigned AW    = CTRL_ADDR_WIDTH;
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic [NUM_REQ-1:0] outst_q, outst_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               busy_q, busy_d;

  logic [AW-1:0]      addr_arr [NUM_REQ];
  logic [LEN_W-1:0]   len_arr  [NUM_REQ];
  logic [NUM_REQ-1:0] elig_c;
  logic [NUM_REQ-1:0] win_oh_c;
  logic [PTR_W-1:0]   win_idx_c;
  logic               win_vld_c;
  logic [AW-1:0]      win_addr_c;
  logic [LEN_W-1:0]   win_len_c;
  logic               win_dir_c;
  logic               win_len_ok_c;

  // Per-channel views, indexed by direction (0 = read, 1 = write).
  logic [NUM_CH-1:0]  ch_ready;
  logic [NUM_CH-1:0]  ch_done_in;
  logic [NUM_CH-1:0]  ch_idle_c;
  logic [NUM_CH-1:0]  ch_issue_c;
  logic [NUM_CH-1:0]  ch_fin_c;
  logic [NUM_CH-1:0]  ch_tmo_c;
  logic [NUM_CH-1:0]  ch_en;
  logic [PTR_W-1:0]   ch_owner [NUM_CH];
  logic [AW-1:0]      ch_addr  [NUM_CH];
  logic [LEN_W-1:0]   ch_len   [NUM_CH];

  assign ch_ready   = {wr_cmd_ready, rd_cmd_ready};
  assign ch_done_in = {wr_cmd_done, rd_cmd_done};

  // Unpack flat request buses and qualify each requester against its channel.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*AW +: AW];
      len_arr[i]  = req_len[i*LEN_W +: LEN_W];
      elig_c[i]   = req[i] & ~outst_q[i] & ch_idle_c[req_dir[i]] & ch_ready[req_dir[i]];
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .eligible     (elig_c),
    .ptr          (rr_ptr_q),
    .winner_oh_c  (win_oh_c),
    .winner_idx_c (win_idx_c),
    .valid_c      (win_vld_c)
  );

  // Winner payload; a bad length is granted but never reaches a channel.
  always_comb begin
    win_addr_c   = addr_arr[win_idx_c];
    win_len_c    = len_arr[win_idx_c];
    win_dir_c    = req_dir[win_idx_c];
    win_len_ok_c = len_ok(win_len_c);
    ch_issue_c   = '0;
    if (win_vld_c && win_len_ok_c) begin
      ch_issue_c[win_dir_c] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic             en_q, en_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             fin_c;
    logic             tmo_c;

    // Channel FSM: latch the command, pulse cmd_en for one cycle, then wait for done or timeout.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      en_d    = 1'b0;
      addr_d  = addr_q;
      len_d   = len_q;
      fin_c   = 1'b0;
      tmo_c   = 1'b0;
      unique case (state_q)
        CH_IDLE: begin
          if (ch_issue_c[g]) begin
            state_d = CH_ISSUE;
            en_d    = 1'b1;
            owner_d = win_idx_c;
            addr_d  = win_addr_c;
            len_d   = win_len_c;
            cnt_d   = '0;
          end
        end
        CH_ISSUE: begin
          state_d = CH_WAIT;
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        end
        CH_WAIT: begin
          if (ch_done_in[g]) begin
            state_d = CH_IDLE;
            fin_c   = 1'b1;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_d = CH_IDLE;
            fin_c   = 1'b1;
            tmo_c   = 1'b1;
          end else begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          end
        end
        default: state_d = CH_IDLE;
      endcase
    end

    // Channel state and command registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= CH_IDLE;
        cnt_q   <= '0;
        owner_q <= '0;
        en_q    <= 1'b0;
        addr_q  <= '0;
        len_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        owner_q <= owner_d;
        en_q    <= en_d;
        addr_q  <= addr_d;
        len_q   <= len_d;
      end
    end

    assign ch_idle_c[g] = (state_q == CH_IDLE);
    assign ch_fin_c[g]  = fin_c;
    assign ch_tmo_c[g]  = tmo_c;
    assign ch_en[g]     = en_q;
    assign ch_owner[g]  = owner_q;
    assign ch_addr[g]   = addr_q;
    assign ch_len[g]    = len_q;
  end

  // Grant/done/err strobes, outstanding mask and round-robin pointer.
  always_comb begin
    grant_d  = '0;
    done_d   = '0;
    err_d    = '0;
    outst_d  = outst_q;
    rr_ptr_d = rr_ptr_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_fin_c[c]) begin
        done_d[ch_owner[c]]  = 1'b1;
        outst_d[ch_owner[c]] = 1'b0;
        if (ch_tmo_c[c]) begin
          err_d[ch_owner[c]] = 1'b1;
        end
      end
    end
    if (win_vld_c) begin
      grant_d  = win_oh_c;
      rr_ptr_d = (32'(win_idx_c) == NUM_REQ - 1) ? '0 : win_idx_c + PTR_W'(1);
      if (win_len_ok_c) begin
        outst_d = outst_d | win_oh_c;
      end else begin
        done_d = done_d | win_oh_c;
        err_d  = err_d | win_oh_c;
      end
    end
    busy_d = |outst_d;
  end

  // Arbiter-level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      outst_q  <= '0;
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      grant_q  <= grant_d;
      done_q   <= done_d;
      err_q    <= err_d;
      outst_q  <= outst_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign wr_cmd_en   = ch_en[DIR_WR];
  assign wr_cmd_addr = ch_addr[DIR_WR];
  assign wr_cmd_len  = ch_len[DIR_WR];
  assign rd_cmd_en   = ch_en[DIR_RD];
  assign rd_cmd_addr = ch_addr[DIR_RD];
  assign rd_cmd_len  = ch_len[DIR_RD];

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Directed bench for ddr_cmd_arbiter (4 requesters, 28-bit addresses, 64-cycle timeout).
module tb_ddr_cmd_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = '0;
  logic [3:0]   req_dir = '0;
  logic [111:0] req_addr = '0;
  logic [127:0] req_len = '0;
  logic [3:0]   grant, done, err;
  logic         wr_cmd_en, rd_cmd_en, busy;
  logic [27:0]  wr_cmd_addr, rd_cmd_addr;
  logic [31:0]  wr_cmd_len, rd_cmd_len;
  logic         wr_cmd_ready = 1'b1;
  logic         wr_cmd_done = 1'b0;
  logic         rd_cmd_ready = 1'b1;
  logic         rd_cmd_done = 1'b0;

  int total = 0;
  int bad = 0;

  ddr_cmd_arbiter #(
    .NUM_REQ         (4),
    .CTRL_ADDR_WIDTH (28),
    .TIMEOUT_CYC     (64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_dir      (req_dir),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .grant        (grant),
    .done         (done),
    .err          (err),
    .wr_cmd_en    (wr_cmd_en),
    .wr_cmd_addr  (wr_cmd_addr),
    .wr_cmd_len   (wr_cmd_len),
    .wr_cmd_ready (wr_cmd_ready),
    .wr_cmd_done  (wr_cmd_done),
    .rd_cmd_en    (rd_cmd_en),
    .rd_cmd_addr  (rd_cmd_addr),
    .rd_cmd_len   (rd_cmd_len),
    .rd_cmd_ready (rd_cmd_ready),
    .rd_cmd_done  (rd_cmd_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic dir, input logic [27:0] a, input logic [31:0] l);
    req_dir[i]          = dir;
    req_addr[i*28 +: 28] = a;
    req_len[i*32 +: 32]  = l;
    req[i]              = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    wr_cmd_done = 1'b0;
    rd_cmd_done = 1'b0;
    wr_cmd_ready = 1'b1;
    rd_cmd_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({grant, done, err} !== 12'h000) begin bad++; $display("FAIL reset_strobes got=%h exp=000", {grant, done, err}); end
    total++; if ({wr_cmd_en, rd_cmd_en, busy} !== 3'b000) begin bad++; $display("FAIL reset_en_busy got=%b exp=000", {wr_cmd_en, rd_cmd_en, busy}); end
    total++; if ({wr_cmd_addr, wr_cmd_len, rd_cmd_addr, rd_cmd_len} !== 120'h0) begin bad++; $display("FAIL reset_cmd got=%h exp=0", {wr_cmd_addr, wr_cmd_len, rd_cmd_addr, rd_cmd_len}); end
    tick();
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_idle_grant got=%b exp=0000", grant); end
  endtask

  task automatic test_single_write();
    do_reset();
    wr_cmd_ready = 1'b0;
    set_req(0, 1'b1, 28'h0000100, 32'd32);
    tick();
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL wr_not_ready_grant got=%b exp=0000", grant); end
    wr_cmd_ready = 1'b1;
    tick();
    req[0] = 1'b0;
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL wr_grant got=%b exp=0001", grant); end
    total++; if ({wr_cmd_en, rd_cmd_en, busy} !== 3'b101) begin bad++; $display("FAIL wr_en got=%b exp=101", {wr_cmd_en, rd_cmd_en, busy}); end
    total++; if (wr_cmd_addr !== 28'h0000100) begin bad++; $display("FAIL wr_addr got=%h exp=0000100", wr_cmd_addr); end
    total++; if (wr_cmd_len !== 32'd32) begin bad++; $display("FAIL wr_len got=%0d exp=32", wr_cmd_len); end
    tick();
    total++; if ({wr_cmd_en, grant, done} !== 9'b0) begin bad++; $display("FAIL wr_en_pulse got=%b exp=0", {wr_cmd_en, grant, done}); end
    wr_cmd_done = 1'b1;
    tick();
    wr_cmd_done = 1'b0;
    total++; if ({done, err} !== 8'b0001_0000) begin bad++; $display("FAIL wr_done got=%b exp=00010000", {done, err}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_clear got=%b exp=0", busy); end
    tick();
    total++; if (done !== 4'b0000) begin bad++; $display("FAIL wr_done_pulse got=%b exp=0000", done); end
  endtask

  task automatic test_round_robin_reads();
    int ord [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_g;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 28'h0001000 + 28'(i * 64), 32'(16 + i));
    for (int n = 0; n < 5; n++) begin
      exp_g = 4'b0001 << ord[n];
      tick();
      total++; if (grant !== exp_g) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", n, grant, exp_g); end
      total++; if (rd_cmd_en !== 1'b1) begin bad++; $display("FAIL rr_en%0d got=%b exp=1", n, rd_cmd_en); end
      total++; if (rd_cmd_addr !== 28'h0001000 + 28'(ord[n] * 64)) begin bad++; $display("FAIL rr_addr%0d got=%h exp=%h", n, rd_cmd_addr, 28'h0001000 + 28'(ord[n] * 64)); end
      total++; if (rd_cmd_len !== 32'(16 + ord[n])) begin bad++; $display("FAIL rr_len%0d got=%0d exp=%0d", n, rd_cmd_len, 16 + ord[n]); end
      tick();
      total++; if ({rd_cmd_en, grant} !== 5'b0) begin bad++; $display("FAIL rr_hold%0d got=%b exp=00000", n, {rd_cmd_en, grant}); end
      rd_cmd_done = 1'b1;
      tick();
      rd_cmd_done = 1'b0;
      if (n == 4) req = '0;
      total++; if ({done, err, grant} !== {exp_g, 8'h00}) begin bad++; $display("FAIL rr_done%0d got=%b exp=%b", n, {done, err, grant}, {exp_g, 8'h00}); end
    end
    tick();
    total++; if ({grant, busy} !== 5'b0) begin bad++; $display("FAIL rr_quiet got=%b exp=00000", {grant, busy}); end
  endtask

  task automatic test_concurrent();
    do_reset();
    set_req(1, 1'b1, 28'h0000200, 32'd40);
    set_req(2, 1'b0, 28'h0000300, 32'd48);
    tick();
    req[1] = 1'b0;
    total++; if ({grant, wr_cmd_en, rd_cmd_en} !== 6'b0010_10) begin bad++; $display("FAIL cc_first got=%b exp=001010", {grant, wr_cmd_en, rd_cmd_en}); end
    total++; if (wr_cmd_addr !== 28'h0000200) begin bad++; $display("FAIL cc_wr_addr got=%h exp=0000200", wr_cmd_addr); end
    tick();
    req[2] = 1'b0;
    total++; if ({grant, wr_cmd_en, rd_cmd_en} !== 6'b0100_01) begin bad++; $display("FAIL cc_second got=%b exp=010001", {grant, wr_cmd_en, rd_cmd_en}); end
    total++; if (rd_cmd_len !== 32'd48) begin bad++; $display("FAIL cc_rd_len got=%0d exp=48", rd_cmd_len); end
    tick();
    total++; if ({grant, wr_cmd_en, rd_cmd_en, busy} !== 7'b0000_001) begin bad++; $display("FAIL cc_wait got=%b exp=0000001", {grant, wr_cmd_en, rd_cmd_en, busy}); end
    wr_cmd_done = 1'b1;
    rd_cmd_done = 1'b1;
    tick();
    wr_cmd_done = 1'b0;
    rd_cmd_done = 1'b0;
    total++; if ({done, err, busy} !== 9'b0110_0000_0) begin bad++; $display("FAIL cc_done got=%b exp=011000000", {done, err, busy}); end
  endtask

  task automatic test_bad_len();
    do_reset();
    set_req(0, 1'b1, 28'h0000400, 32'd8);
    tick();
    req[0] = 1'b0;
    total++; if ({grant, wr_cmd_en} !== 5'b0001_1) begin bad++; $display("FAIL bl_wr_grant got=%b exp=00011", {grant, wr_cmd_en}); end
    set_req(3, 1'b0, 28'h0000500, 32'd0);
    tick();
    req[3] = 1'b0;
    total++; if ({grant, done, err} !== 12'b1000_1000_1000) begin bad++; $display("FAIL bl_zero got=%b exp=100010001000", {grant, done, err}); end
    total++; if ({wr_cmd_en, rd_cmd_en, busy} !== 3'b001) begin bad++; $display("FAIL bl_zero_en got=%b exp=001", {wr_cmd_en, rd_cmd_en, busy}); end
    set_req(2, 1'b0, 28'h0000600, 32'h00010000);
    tick();
    req[2] = 1'b0;
    total++; if ({grant, done, err, rd_cmd_en} !== 13'b0100_0100_0100_0) begin bad++; $display("FAIL bl_big got=%b exp=0100010001000", {grant, done, err, rd_cmd_en}); end
    set_req(1, 1'b0, 28'h0000700, 32'd65535);
    tick();
    req[1] = 1'b0;
    total++; if ({grant, done, err, rd_cmd_en} !== 13'b0010_0000_0000_1) begin bad++; $display("FAIL bl_max got=%b exp=0010000000001", {grant, done, err, rd_cmd_en}); end
    total++; if (rd_cmd_len !== 32'd65535) begin bad++; $display("FAIL bl_max_len got=%0d exp=65535", rd_cmd_len); end
    wr_cmd_done = 1'b1;
    tick();
    wr_cmd_done = 1'b0;
    total++; if ({done, err, busy} !== 9'b0001_0000_1) begin bad++; $display("FAIL bl_wr_done got=%b exp=000100001", {done, err, busy}); end
    rd_cmd_done = 1'b1;
    tick();
    rd_cmd_done = 1'b0;
    total++; if ({done, err, busy} !== 9'b0010_0000_0) begin bad++; $display("FAIL bl_rd_done got=%b exp=001000000", {done, err, busy}); end
  endtask

  task automatic test_timeout();
    int early;
    do_reset();
    set_req(0, 1'b1, 28'h0000800, 32'd4);
    tick();
    req[0] = 1'b0;
    total++; if ({grant, wr_cmd_en} !== 5'b0001_1) begin bad++; $display("FAIL to_grant got=%b exp=00011", {grant, wr_cmd_en}); end
    early = 0;
    for (int k = 1; k < 64; k++) begin
      tick();
      if (done !== 4'b0000) early++;
    end
    total++; if (early !== 0) begin bad++; $display("FAIL to_early got=%0d exp=0", early); end
    tick();
    total++; if ({done, err, busy} !== 9'b0001_0001_0) begin bad++; $display("FAIL to_abort got=%b exp=000100010", {done, err, busy}); end
    set_req(1, 1'b1, 28'h0000900, 32'd5);
    tick();
    req[1] = 1'b0;
    total++; if ({grant, wr_cmd_en} !== 5'b0010_1) begin bad++; $display("FAIL to_regrant got=%b exp=00101", {grant, wr_cmd_en}); end
    total++; if (wr_cmd_addr !== 28'h0000900) begin bad++; $display("FAIL to_addr got=%h exp=0000900", wr_cmd_addr); end
    tick();
    wr_cmd_done = 1'b1;
    tick();
    wr_cmd_done = 1'b0;
    total++; if ({done, err} !== 8'b0010_0000) begin bad++; $display("FAIL to_done got=%b exp=00100000", {done, err}); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    set_req(2, 1'b1, 28'h0000A00, 32'd20);
    tick();
    req[2] = 1'b0;
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL rm_grant got=%b exp=0100", grant); end
    tick();
    rst = 1'b1;
    wr_cmd_done = 1'b1;
    tick();
    wr_cmd_done = 1'b0;
    total++; if ({grant, done, err, wr_cmd_en, rd_cmd_en, busy} !== 15'b0) begin bad++; $display("FAIL rm_outs got=%b exp=0", {grant, done, err, wr_cmd_en, rd_cmd_en, busy}); end
    total++; if ({wr_cmd_addr, wr_cmd_len} !== 60'h0) begin bad++; $display("FAIL rm_cmd got=%h exp=0", {wr_cmd_addr, wr_cmd_len}); end
    rst = 1'b0;
    tick();
    total++; if (done !== 4'b0000) begin bad++; $display("FAIL rm_no_done got=%b exp=0000", done); end
    set_req(2, 1'b0, 28'h0000B00, 32'd24);
    tick();
    req[2] = 1'b0;
    total++; if ({grant, rd_cmd_en} !== 5'b0100_1) begin bad++; $display("FAIL rm_fresh got=%b exp=01001", {grant, rd_cmd_en}); end
    total++; if (rd_cmd_addr !== 28'h0000B00) begin bad++; $display("FAIL rm_addr got=%h exp=0000b00", rd_cmd_addr); end
    tick();
    rd_cmd_done = 1'b1;
    tick();
    rd_cmd_done = 1'b0;
    total++; if (done !== 4'b0100) begin bad++; $display("FAIL rm_done got=%b exp=0100", done); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin_reads();
    test_concurrent();
    test_bad_len();
    test_timeout();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
